// File: rtl/song_pkg.sv
// Shared types and pitch constants for the song sequencer.
// Pitch table is built from C0-octave frequencies in millihertz.
package song_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        LATCH,
        PLAY,
        ADVANCE,
        DONE
    } state_t;

    localparam int DIV_W = 22;
    localparam logic [7:0] NOTE_REST = 8'd0;

    // C0..B0 equal-tempered frequencies, millihertz
    localparam int unsigned C0_MHZ [12] = '{
        16352, 17324, 18354, 19445, 20602, 21827,
        23125, 24500, 25957, 27500, 29135, 30868
    };

    // Half-period in clocks of semitone 'semi' in octave 0
    function automatic logic [DIV_W-1:0] base_half(
        input longint unsigned clk_hz,
        input int              semi
    );
        longint unsigned num;
        longint unsigned den;
        longint unsigned v;
        num = clk_hz * 64'd1000;
        den = 64'(C0_MHZ[semi]) * 64'd2;
        v   = num / den;
        return v[DIV_W-1:0];
    endfunction

endpackage

// File: rtl/note_to_divider.sv
// Registered note code to tone half-period lookup.
// Loads on the LATCH cycle so divider is ready for PLAY.
module note_to_divider #(
    parameter int unsigned CLK_HZ       = 100_000_000,
    parameter int unsigned OCTAVE_SHIFT = 2
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      load,
    input  logic [7:0]                note,
    output logic [song_pkg::DIV_W-1:0] divider
);
    import song_pkg::*;

    localparam logic [DIV_W-1:0] BASE_HALF [12] = '{
        base_half(CLK_HZ, 0),  base_half(CLK_HZ, 1),
        base_half(CLK_HZ, 2),  base_half(CLK_HZ, 3),
        base_half(CLK_HZ, 4),  base_half(CLK_HZ, 5),
        base_half(CLK_HZ, 6),  base_half(CLK_HZ, 7),
        base_half(CLK_HZ, 8),  base_half(CLK_HZ, 9),
        base_half(CLK_HZ, 10), base_half(CLK_HZ, 11)
    };

    logic [8:0]       e;
    logic [8:0]       semi;
    logic [8:0]       oct;
    logic [DIV_W-1:0] base;

    // Split shifted note into semitone and octave, pick base period
    always_comb begin
        e    = {1'b0, note} + 9'(12 * OCTAVE_SHIFT);
        semi = e % 9'd12;
        oct  = e / 9'd12;
        base = '0;
        for (int i = 0; i < 12; i++) begin
            if (semi == 9'(i)) base = BASE_HALF[i];
        end
    end

    // Capture the octave-shifted divider for the new note
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            divider <= '0;
        end else if (load) begin
            divider <= base >> oct;
        end
    end

endmodule

// File: rtl/song_sequencer.sv
// Song ROM sequencer: steps note slots at a fixed beat and
// renders each note as a square wave on audio_out.
module song_sequencer #(
    parameter int unsigned CLK_HZ       = 100_000_000,
    parameter int unsigned BEAT_CYCLES  = 25_000_000,
    parameter int unsigned GAP_CYCLES   = 2_500_000,
    parameter int unsigned LAST_ADDR    = 254,
    parameter int unsigned LOOP         = 1,
    parameter int unsigned OCTAVE_SHIFT = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       play,
    input  logic       restart,
    input  logic [7:0] note,
    output logic [7:0] address,
    output logic       audio_out,
    output logic [7:0] cur_note,
    output logic       busy,
    output logic       done
);
    import song_pkg::*;

    localparam logic [31:0] BEAT_LAST = 32'(BEAT_CYCLES - 1);
    localparam logic [31:0] SOUND_END = 32'(BEAT_CYCLES - GAP_CYCLES);

    state_t           state;
    logic [31:0]      beat_cnt;
    logic [DIV_W-1:0] tone_cnt;
    logic             phase;
    logic [DIV_W-1:0] divider;
    logic             load;
    logic             sound;
    logic             wrap;
    logic             ph_n;
    logic             in_gap;

    assign load = (state == LATCH) && play && !restart;

    note_to_divider #(
        .CLK_HZ       (CLK_HZ),
        .OCTAVE_SHIFT (OCTAVE_SHIFT)
    ) u_div (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (load),
        .note    (note),
        .divider (divider)
    );

    // Tone toggle and mute decisions for the current PLAY clock
    always_comb begin
        sound  = (cur_note != NOTE_REST) && !cur_note[7]
                 && (divider != '0);
        wrap   = (tone_cnt == divider - DIV_W'(1));
        ph_n   = phase ^ wrap;
        in_gap = (beat_cnt + 32'd1) >= SOUND_END;
    end

    // Slot sequencing FSM with registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            address   <= '0;
            audio_out <= 1'b0;
            cur_note  <= NOTE_REST;
            busy      <= 1'b0;
            done      <= 1'b0;
            beat_cnt  <= '0;
            tone_cnt  <= '0;
            phase     <= 1'b0;
        end else if (restart) begin
            address   <= '0;
            audio_out <= 1'b0;
            cur_note  <= NOTE_REST;
            done      <= 1'b0;
            beat_cnt  <= '0;
            tone_cnt  <= '0;
            phase     <= 1'b0;
            busy      <= play;
            state     <= play ? FETCH : IDLE;
        end else begin
            unique case (state)
                IDLE: begin
                    if (play) begin
                        state <= FETCH;
                        busy  <= 1'b1;
                    end
                end
                DONE: begin
                    audio_out <= 1'b0;
                    done      <= 1'b1;
                end
                default: begin
                    if (!play) begin
                        audio_out <= 1'b0;
                    end else begin
                        unique case (state)
                            FETCH: state <= LATCH;
                            LATCH: begin
                                cur_note  <= note;
                                beat_cnt  <= '0;
                                tone_cnt  <= '0;
                                phase     <= 1'b0;
                                audio_out <= 1'b0;
                                state     <= PLAY;
                            end
                            PLAY: begin
                                beat_cnt  <= beat_cnt + 32'd1;
                                tone_cnt  <= wrap ? '0
                                           : tone_cnt + DIV_W'(1);
                                phase     <= ph_n;
                                audio_out <= ph_n && sound && !in_gap;
                                if (beat_cnt == BEAT_LAST) begin
                                    state <= ADVANCE;
                                end
                            end
                            ADVANCE: begin
                                audio_out <= 1'b0;
                                if (address == 8'(LAST_ADDR)) begin
                                    if (LOOP != 0) begin
                                        address <= '0;
                                        state   <= FETCH;
                                    end else begin
                                        state    <= DONE;
                                        busy     <= 1'b0;
                                        done     <= 1'b1;
                                        cur_note <= NOTE_REST;
                                    end
                                end else begin
                                    address <= address + 8'd1;
                                    state   <= FETCH;
                                end
                            end
                            default: begin
                                state <= IDLE;
                                busy  <= 1'b0;
                            end
                        endcase
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_song_sequencer.sv
// Randomized bench for song_sequencer against a slot-level model.
// Two instances: looping (last 7) and one-shot (last 3).
module tb_song_sequencer;

    localparam int CLKHZ = 500_000;
    localparam int BEAT  = 4000;
    localparam int GAP   = 400;
    localparam int LAST [2] = '{7, 3};
    localparam int LOOPP[2] = '{1, 0};

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       play = 1'b0;
    logic       restart = 1'b0;
    logic [7:0] note_i   [2];
    logic [7:0] addr_o   [2];
    logic       audio_o  [2];
    logic [7:0] cur_o    [2];
    logic       busy_o   [2];
    logic       done_o   [2];

    logic [7:0] rom [256];

    int errs = 0;
    int checks = 0;

    int m_mode [2];
    int m_s    [2];
    int m_addr [2];
    int m_aud  [2];

    always #5 clk = ~clk;

    song_sequencer #(
        .CLK_HZ(CLKHZ), .BEAT_CYCLES(BEAT), .GAP_CYCLES(GAP),
        .LAST_ADDR(7), .LOOP(1), .OCTAVE_SHIFT(2)
    ) dut_a (
        .clk(clk), .rst_n(rst_n), .play(play), .restart(restart),
        .note(note_i[0]), .address(addr_o[0]), .audio_out(audio_o[0]),
        .cur_note(cur_o[0]), .busy(busy_o[0]), .done(done_o[0])
    );

    song_sequencer #(
        .CLK_HZ(CLKHZ), .BEAT_CYCLES(BEAT), .GAP_CYCLES(GAP),
        .LAST_ADDR(3), .LOOP(0), .OCTAVE_SHIFT(2)
    ) dut_b (
        .clk(clk), .rst_n(rst_n), .play(play), .restart(restart),
        .note(note_i[1]), .address(addr_o[1]), .audio_out(audio_o[1]),
        .cur_note(cur_o[1]), .busy(busy_o[1]), .done(done_o[1])
    );

    // Synchronous ROM: note valid one clock after address
    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) note_i[i] <= rom[addr_o[i]];
    end

    task automatic check(input string tag, input longint got,
                         input longint exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    function automatic int ref_div(input int n);
        int f_mhz [12] = '{16352, 17324, 18354, 19445, 20602, 21827,
                           23125, 24500, 25957, 27500, 29135, 30868};
        int e;
        longint h;
        e = n + 24;
        h = (longint'(CLKHZ) * 1000) / (2 * f_mhz[e % 12]);
        return int'(h >> (e / 12));
    endfunction

    // Audio level at slot offset s (s=0 is the FETCH cycle)
    function automatic int tone_at(input int n, input int s);
        int j;
        int d;
        if (s < 3 || n == 0 || n > 127) return 0;
        j = s - 2;
        d = ref_div(n);
        if (d == 0 || j >= BEAT - GAP) return 0;
        return (j / d) % 2;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_mode[i] = 0;
            m_s[i]    = 0;
            m_addr[i] = 0;
            m_aud[i]  = 0;
        end
    endtask

    task automatic model_edge(input int i);
        if (restart) begin
            m_addr[i] = 0;
            m_s[i]    = 0;
            m_aud[i]  = 0;
            m_mode[i] = play ? 1 : 0;
        end else if (m_mode[i] == 0) begin
            if (play) begin
                m_mode[i] = 1;
                m_s[i]    = 0;
            end
        end else if (m_mode[i] == 2) begin
            m_aud[i] = 0;
        end else if (!play) begin
            m_aud[i] = 0;
        end else if (m_s[i] == BEAT + 2) begin
            m_aud[i] = 0;
            m_s[i]   = 0;
            if (m_addr[i] == LAST[i]) begin
                if (LOOPP[i] != 0) m_addr[i] = 0;
                else m_mode[i] = 2;
            end else begin
                m_addr[i]++;
            end
        end else begin
            m_s[i]++;
            m_aud[i] = tone_at(rom[m_addr[i]], m_s[i]);
        end
    endtask

    task automatic compare_all();
        for (int i = 0; i < 2; i++) begin
            check($sformatf("addr%0d", i), addr_o[i], m_addr[i]);
            check($sformatf("audio%0d", i), audio_o[i], m_aud[i]);
            check($sformatf("busy%0d", i), busy_o[i], m_mode[i] == 1);
            check($sformatf("done%0d", i), done_o[i], m_mode[i] == 2);
            if (m_mode[i] == 1 && m_s[i] >= 2)
                check($sformatf("cur%0d", i), cur_o[i], rom[m_addr[i]]);
        end
    endtask

    task automatic step();
        @(posedge clk);
        if (rst_n) begin
            for (int i = 0; i < 2; i++) model_edge(i);
        end
        #1;
        compare_all();
    endtask

    initial begin
        int rises;
        int t1;
        int hi;
        logic prev;
        bit found;

        for (int a = 0; a < 256; a++) rom[a] = 8'($urandom);
        rom[0] = 8'd33;
        rom[5] = 8'd0;
        model_reset();

        repeat (3) step();
        for (int i = 0; i < 2; i++) begin
            check($sformatf("rst_cur%0d", i), cur_o[i], 0);
            check($sformatf("rst_aud%0d", i), audio_o[i], 0);
            check($sformatf("rst_addr%0d", i), addr_o[i], 0);
        end
        rst_n = 1'b1;
        repeat (5) step();

        play  = 1'b1;
        rises = 0;
        t1    = 0;
        hi    = 0;
        prev  = 1'b0;
        for (int n = 0; n < 38000; n++) begin
            play = !(n >= 6000 && n < 7000);
            step();
            if (n < BEAT + 3) begin
                if (audio_o[0] && !prev) begin
                    rises++;
                    if (rises == 1) t1 = n;
                    else if (rises == 2)
                        check("period_a4", n - t1, 1136);
                end
                if (rises == 1 && audio_o[0]) hi++;
                prev = audio_o[0];
            end
            if (n == 2000) check("cur_33", cur_o[0], 33);
        end
        check("duty_hi", hi, 568);
        check("done_b", done_o[1], 1);
        check("done_addr_b", addr_o[1], 3);

        restart = 1'b1;
        step();
        restart = 1'b0;
        for (int i = 0; i < 2; i++) begin
            check($sformatf("rs_addr%0d", i), addr_o[i], 0);
            check($sformatf("rs_busy%0d", i), busy_o[i], 1);
            check($sformatf("rs_done%0d", i), done_o[i], 0);
        end
        repeat (5000) step();

        restart = 1'b1;
        play    = 1'b0;
        step();
        restart = 1'b0;
        for (int i = 0; i < 2; i++) begin
            check($sformatf("rsi_addr%0d", i), addr_o[i], 0);
            check($sformatf("rsi_busy%0d", i), busy_o[i], 0);
            check($sformatf("rsi_aud%0d", i), audio_o[i], 0);
        end
        repeat (20) step();

        for (int n = 0; n < 10000; n++) begin
            play = ($urandom_range(0, 99) < 90);
            step();
        end

        play  = 1'b1;
        found = 1'b0;
        for (int n = 0; n < 6000 && !found; n++) begin
            step();
            if (audio_o[0]) found = 1'b1;
        end
        check("wait_tone", found, 1);
        #3 rst_n = 1'b0;
        #1;
        model_reset();
        for (int i = 0; i < 2; i++) begin
            check($sformatf("ar_addr%0d", i), addr_o[i], 0);
            check($sformatf("ar_aud%0d", i), audio_o[i], 0);
            check($sformatf("ar_cur%0d", i), cur_o[i], 0);
            check($sformatf("ar_busy%0d", i), busy_o[i], 0);
            check($sformatf("ar_done%0d", i), done_o[i], 0);
        end
        repeat (2) step();
        rst_n = 1'b1;
        repeat (500) step();

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
